// File: rtl/mole_hit_detector_if.sv
// ---------------------------------------------------------------------------
// mole_hit_detector_if
//   Bundles the game-side signals of the mole hit detector.
//   master : the driver side (mole generator / button pad / testbench)
//            drives game_active, btn_raw and mole_active and observes results.
//   slave  : the detector itself.
// Signals
//   game_active  1 = presses are scored
//   btn_raw      raw asynchronous push-buttons, 1 = pressed
//   mole_active  currently lit moles (synchronous to the detector clock)
//   hit_inc      1-cycle pulse per scored hit (score counter increment)
//   miss_pulse   1-cycle pulse when a press matches no lit mole
//   hit_index    index of the last scored hit, held until the next hit
//   mole_clear   1-cycle mask of moles hit by this event
//   busy         1 while presses are locked out
// ---------------------------------------------------------------------------
interface mole_hit_detector_if #(
  parameter int NUM_MOLES = 8
);
  logic                 game_active;
  logic [NUM_MOLES-1:0] btn_raw;
  logic [NUM_MOLES-1:0] mole_active;
  logic                 hit_inc;
  logic                 miss_pulse;
  logic [3:0]           hit_index;
  logic [NUM_MOLES-1:0] mole_clear;
  logic                 busy;

  modport master (
    output game_active, btn_raw, mole_active,
    input  hit_inc, miss_pulse, hit_index, mole_clear, busy
  );

  modport slave (
    input  game_active, btn_raw, mole_active,
    output hit_inc, miss_pulse, hit_index, mole_clear, busy
  );
endinterface

// File: rtl/mole_hit_detector.sv
// ---------------------------------------------------------------------------
// mole_hit_detector
//   Conditions the player's raw buttons (2-flop synchronizer, per-button
//   debounce, rising-edge detect), matches each new press against the lit
//   moles and produces registered, mutually exclusive hit/miss pulses for the
//   score counter, plus hit position, clear mask and a lockout busy flag.
// Ports
//   clock  system clock, all state on posedge
//   reset  asynchronous, active-low
//   bus    mole_hit_detector_if.slave (game_active, btn_raw, mole_active in;
//          hit_inc, miss_pulse, hit_index, mole_clear, busy out)
// ---------------------------------------------------------------------------
module mole_hit_detector #(
  parameter int NUM_MOLES       = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  mole_hit_detector_if.slave    bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  // ---------------- input conditioning ----------------
  logic [NUM_MOLES-1:0] sync1_q, sync2_q;
  logic [NUM_MOLES-1:0] deb_q, deb_d;
  logic [NUM_MOLES-1:0] deb_prev_q;
  logic [NUM_MOLES-1:0] press;
  logic [NUM_MOLES-1:0] match;
  logic [3:0]           match_idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
    end else begin
      sync1_q    <= bus.btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

  // Per-button debounce: a level is accepted only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement with the current debounced value.
  for (genvar gi = 0; gi < NUM_MOLES; gi++) begin : g_deb
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_bit_d;

    always_comb begin
      cnt_d     = '0;
      deb_bit_d = deb_q[gi];
      if (sync2_q[gi] != deb_q[gi]) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_bit_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign deb_d[gi] = deb_bit_d;
  end

  // One-cycle pulse per accepted press; releases are ignored.
  assign press = deb_q & ~deb_prev_q;
  assign match = press & bus.mole_active;

  // Lowest set bit of match wins the reported index.
  always_comb begin
    match_idx = 4'd0;
    for (int i = NUM_MOLES - 1; i >= 0; i--) begin
      if (match[i]) match_idx = 4'(i);
    end
  end

  // ---------------- scoring FSM ----------------
  state_t               state_q;
  logic [LW-1:0]        lock_cnt_q;
  logic                 hit_inc_q;
  logic                 miss_pulse_q;
  logic [3:0]           hit_index_q;
  logic [NUM_MOLES-1:0] mole_clear_q;
  logic                 busy_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lock_cnt_q   <= '0;
      hit_inc_q    <= 1'b0;
      miss_pulse_q <= 1'b0;
      hit_index_q  <= 4'd0;
      mole_clear_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      hit_inc_q    <= 1'b0;
      miss_pulse_q <= 1'b0;
      mole_clear_q <= '0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.game_active) state_q <= ARMED;
        end
        ARMED: begin
          // Leaving the game takes priority over a press in the same cycle.
          if (!bus.game_active) begin
            state_q <= IDLE;
          end else if (|press) begin
            if (|match) begin
              hit_inc_q    <= 1'b1;
              mole_clear_q <= match;
              hit_index_q  <= match_idx;
            end else begin
              miss_pulse_q <= 1'b1;
            end
            state_q    <= LOCKOUT;
            lock_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        LOCKOUT: begin
          if (!bus.game_active) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (lock_cnt_q == LW'(LOCKOUT_CYCLES - 1)) begin
            state_q <= ARMED;
            busy_q  <= 1'b0;
          end else begin
            lock_cnt_q <= lock_cnt_q + LW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hit_inc    = hit_inc_q;
  assign bus.miss_pulse = miss_pulse_q;
  assign bus.hit_index  = hit_index_q;
  assign bus.mole_clear = mole_clear_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mole_hit_detector.sv
// Directed bench for mole_hit_detector (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8).
// Inputs are driven 1 time unit after a rising edge; a negedge monitor
// accumulates pulses so multi-cycle behaviour can be checked by count.
module tb_mole_hit_detector;

  localparam int N   = 8;
  localparam int DEB = 4;
  localparam int LCK = 8;
  localparam int LAT = DEB + 3;

  logic clk;
  logic rst_n;

  mole_hit_detector_if #(.NUM_MOLES(N)) bus_if ();

  mole_hit_detector #(
    .NUM_MOLES(N), .DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LCK)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // monitor state
  int           cyc = 0;
  int           hits, misses, busy_cyc, evt_cyc, both;
  logic [N-1:0] clr_acc;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus_if.hit_inc)    hits++;
    if (bus_if.miss_pulse) misses++;
    if (bus_if.busy)       busy_cyc++;
    if (bus_if.hit_inc && bus_if.miss_pulse) both++;
    clr_acc = clr_acc | bus_if.mole_clear;
    if ((bus_if.hit_inc || bus_if.miss_pulse) && evt_cyc == 0) evt_cyc = cyc;
  end

  task automatic clr_mon();
    hits = 0; misses = 0; busy_cyc = 0; evt_cyc = 0; both = 0; clr_acc = '0;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  typedef struct {
    logic [N-1:0] ma;
    logic [N-1:0] btn;
    int           hit;
    int           miss;
    int           idx;
    logic [N-1:0] clr;
  } vec_t;

  vec_t vecs [7];
  int   step_cyc;

  initial begin
    vecs[0] = '{ma: 8'h04, btn: 8'h04, hit: 1, miss: 0, idx: 2, clr: 8'h04};
    vecs[1] = '{ma: 8'h00, btn: 8'h02, hit: 0, miss: 1, idx: 2, clr: 8'h00};
    vecs[2] = '{ma: 8'h0A, btn: 8'h0A, hit: 1, miss: 0, idx: 1, clr: 8'h0A};
    vecs[3] = '{ma: 8'h81, btn: 8'h81, hit: 1, miss: 0, idx: 0, clr: 8'h81};
    vecs[4] = '{ma: 8'h10, btn: 8'h30, hit: 1, miss: 0, idx: 4, clr: 8'h10};
    vecs[5] = '{ma: 8'hF0, btn: 8'h0F, hit: 0, miss: 1, idx: 4, clr: 8'h00};
    vecs[6] = '{ma: 8'h80, btn: 8'h80, hit: 1, miss: 0, idx: 7, clr: 8'h80};

    clr_mon();
    rst_n = 1'b0;
    bus_if.game_active = 1'b0;
    bus_if.btn_raw     = '0;
    bus_if.mole_active = '0;
    tick(3);
    chk("reset_hit_inc",    int'(bus_if.hit_inc),    0);
    chk("reset_miss",       int'(bus_if.miss_pulse), 0);
    chk("reset_hit_index",  int'(bus_if.hit_index),  0);
    chk("reset_mole_clear", int'(bus_if.mole_clear), 0);
    chk("reset_busy",       int'(bus_if.busy),       0);
    rst_n = 1'b1;
    bus_if.game_active = 1'b1;
    tick(3);

    // ---- table-driven single events ----
    for (int i = 0; i < 7; i++) begin
      clr_mon();
      bus_if.mole_active = vecs[i].ma;
      bus_if.btn_raw     = vecs[i].btn;
      step_cyc = cyc;
      tick(25);
      chk($sformatf("v%0d_hits", i),    hits,   vecs[i].hit);
      chk($sformatf("v%0d_misses", i),  misses, vecs[i].miss);
      chk($sformatf("v%0d_index", i),   int'(bus_if.hit_index), vecs[i].idx);
      chk($sformatf("v%0d_clear", i),   int'(clr_acc), int'(vecs[i].clr));
      chk($sformatf("v%0d_busy", i),    busy_cyc, LCK);
      chk($sformatf("v%0d_latency", i), evt_cyc - step_cyc, LAT);
      chk($sformatf("v%0d_exclusive", i), both, 0);
      bus_if.btn_raw = '0;
      tick(20);
      chk($sformatf("v%0d_release_quiet", i), hits + misses, vecs[i].hit + vecs[i].miss);
    end

    // ---- bouncing button ----
    clr_mon();
    bus_if.mole_active = 8'h20;
    for (int p = 0; p < 5; p++) begin
      bus_if.btn_raw = 8'h20; tick(2);
      bus_if.btn_raw = 8'h00; tick(2);
    end
    chk("bounce_no_event", hits + misses, 0);
    bus_if.btn_raw = 8'h20;
    step_cyc = cyc;
    tick(25);
    chk("bounce_hits", hits, 1);
    chk("bounce_latency", evt_cyc - step_cyc, LAT);
    bus_if.btn_raw = '0;
    tick(20);

    // ---- press during lockout dropped, press after busy scored ----
    clr_mon();
    bus_if.mole_active = 8'h0C;
    bus_if.btn_raw     = 8'h04;
    tick(3);
    bus_if.btn_raw     = 8'h0C;   // btn3 accepted 3 cycles after the hit
    tick(25);
    chk("lockout_hits", hits, 1);
    chk("lockout_clear", int'(clr_acc), 8'h04);
    bus_if.mole_active = 8'h0E;
    bus_if.btn_raw     = 8'h0E;
    tick(25);
    chk("after_busy_hits", hits, 2);
    chk("after_busy_index", int'(bus_if.hit_index), 1);
    bus_if.btn_raw = '0;
    tick(20);

    // ---- game inactive ignores presses ----
    bus_if.game_active = 1'b0;
    tick(2);
    clr_mon();
    bus_if.mole_active = 8'h01;
    bus_if.btn_raw     = 8'h01;
    tick(25);
    chk("inactive_events", hits + misses, 0);
    chk("inactive_busy", busy_cyc, 0);
    bus_if.btn_raw = '0;
    tick(20);
    bus_if.game_active = 1'b1;
    tick(2);

    // ---- game_active drop aborts lockout at once ----
    clr_mon();
    bus_if.btn_raw = 8'h01;
    tick(9);
    chk("drop_busy_before", int'(bus_if.busy), 1);
    bus_if.game_active = 1'b0;
    tick(1);
    chk("drop_busy_after", int'(bus_if.busy), 0);
    bus_if.game_active = 1'b1;
    bus_if.btn_raw = '0;
    tick(20);

    // ---- reset mid-debounce: held button scored once after release ----
    clr_mon();
    bus_if.mole_active = 8'h04;
    bus_if.btn_raw     = 8'h04;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("rst_debounce_busy", int'(bus_if.busy), 0);
    tick(2);
    rst_n = 1'b1;
    tick(25);
    chk("rst_debounce_hits", hits, 1);
    chk("rst_debounce_index", int'(bus_if.hit_index), 2);
    bus_if.btn_raw = '0;
    tick(20);

    // ---- reset mid-lockout: outputs clear immediately ----
    clr_mon();
    bus_if.btn_raw = 8'h04;
    tick(9);
    chk("rst_lock_busy_before", int'(bus_if.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_lock_busy", int'(bus_if.busy), 0);
    chk("rst_lock_index", int'(bus_if.hit_index), 0);
    chk("rst_lock_hit_inc", int'(bus_if.hit_inc), 0);
    tick(2);
    rst_n = 1'b1;
    tick(25);
    chk("rst_lock_hits", hits, 2);
    chk("rst_lock_misses", misses, 0);
    bus_if.btn_raw = '0;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
